// File: rtl/dtcm_mp_pkg.sv
// dtcm_mp_pkg: shared constants for the multi-port DTCM and its arbiter.
//   DTCM_ARB_FIXED / DTCM_ARB_RR : arbitration mode encodings
//   DTCM_DEFAULT_DEPTH           : default array depth in words
//   idx_width()                  : width of an index into n items (min 1)
package dtcm_mp_pkg;

  localparam int DTCM_ARB_FIXED     = 0;
  localparam int DTCM_ARB_RR        = 1;
  localparam int DTCM_DEFAULT_DEPTH = 8192;

  // A single-entry set still needs a 1-bit index to keep ports legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcm_rr_arbiter.sv
// tcm_rr_arbiter: per-cycle single-grant arbiter shared by the TCMs.
//   clk, rstn : clock, synchronous active-low reset
//   req       : per-requester request bits
//   accept    : high when the current grant is consumed this cycle
//   grant     : one-hot grant (combinational from req and last_grant)
//   grant_idx : encoded index of grant
// MODE 0 picks the lowest index; MODE 1 searches from last_grant+1.
module tcm_rr_arbiter
  import dtcm_mp_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = DTCM_ARB_FIXED,
  localparam int IW  = idx_width(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] last_grant_d;
  logic [IW-1:0] cand_s;
  logic          found_s;

  // Priority search; in RR mode the search window starts after the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == DTCM_ARB_RR) begin
        cand_s = IW'((int'(last_grant_q) + 1 + k) % N);
      end else begin
        cand_s = IW'(k);
      end
      if (!found_s && req[cand_s]) begin
        found_s          = 1'b1;
        grant[cand_s]    = 1'b1;
        grant_idx        = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    last_grant_d = (accept && found_s) ? grant_idx : last_grant_q;
  end

  // last_grant resets to N-1 so port 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q <= IW'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dtcm_mp.sv
// dtcm_mp: multi-port data TCM over one single-ported word array.
//   clk, rstn : clock, synchronous active-low reset
//   req_*     : per-port request channel (valid/ready, we, strb, addr, wdata)
//   rsp_valid : per-port one-cycle response pulse
//   rsp_err   : per-port out-of-range flag, qualified by rsp_valid
//   rsp_rdata : shared read data, meaningful for the responding port only
// One access per cycle; response READ_LATENCY (1 or 2) cycles after accept.
module dtcm_mp
  import dtcm_mp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = DTCM_DEFAULT_DEPTH,
  parameter int NUM_PORTS    = 3,
  parameter int ARB_MODE     = DTCM_ARB_FIXED,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_strb,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [NUM_PORTS-1:0]              rsp_err,
  output logic [DATA_WIDTH-1:0]             rsp_rdata
);

  localparam int SB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(SB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW    = idx_width(NUM_PORTS);

  logic [PW-1:0]         gnt_idx_s;
  logic                  accept_s;
  logic                  sel_we_s;
  logic [SB-1:0]         sel_strb_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [IDX_W-1:0]      word_idx_s;
  logic                  oor_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] mem_dout_s;

  tcm_rr_arbiter #(.N(NUM_PORTS), .MODE(ARB_MODE)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_valid),
    .accept    (accept_s),
    .grant     (req_ready),
    .grant_idx (gnt_idx_s)
  );

  // Route the granted port's payload and decode the address.
  always_comb begin
    accept_s    = |(req_valid & req_ready);
    sel_we_s    = 1'b0;
    sel_strb_s  = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (req_ready[p]) begin
        sel_we_s    = req_we[p];
        sel_strb_s  = req_strb[p*SB +: SB];
        sel_addr_s  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
    word_idx_s = sel_addr_s[OFF_W +: IDX_W];
    // Any address at or beyond the array's byte span is out of range.
    oor_s      = ({1'b0, sel_addr_s} >= (ADDR_WIDTH + 1)'(DEPTH * SB));
    // Writes land even while rstn is low; only the response path is reset.
    wr_en_s    = accept_s & sel_we_s & ~oor_s;
    rd_en_s    = accept_s & ~sel_we_s & ~oor_s;
  end

`ifndef ASIC
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  // Byte-strobed array with one-cycle registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < SB; b++) begin
        if (sel_strb_s[b]) begin
          mem_q[word_idx_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
        end
      end
    end
    if (rd_en_s) begin
      dout_q <= mem_q[word_idx_s];
    end
  end

  assign mem_dout_s = dout_q;
`else
  tcm_sram_sp #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_sram (
    .clk  (clk),
    .ce   (wr_en_s | rd_en_s),
    .we   (wr_en_s),
    .bwe  (sel_strb_s),
    .addr (word_idx_s),
    .din  (sel_wdata_s),
    .dout (mem_dout_s)
  );
`endif

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_port_q, s1_port_d;
  logic          s1_err_q, s1_err_d;
  logic          s1_rd_q, s1_rd_d;
  logic [DATA_WIDTH-1:0] s1_data_s;

  logic                  out_valid_s;
  logic [PW-1:0]         out_port_s;
  logic                  out_err_s;
  logic [DATA_WIDTH-1:0] out_data_s;

  // First response stage tracks who was served and whether data is due.
  always_comb begin
    s1_valid_d = accept_s;
    s1_port_d  = gnt_idx_s;
    s1_err_d   = oor_s;
    s1_rd_d    = rd_en_s;
    // Writes and out-of-range accesses return zero data.
    s1_data_s  = s1_rd_q ? mem_dout_s : '0;
  end

  // First response stage registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_port_q  <= '0;
      s1_err_q   <= 1'b0;
      s1_rd_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_port_q  <= s1_port_d;
      s1_err_q   <= s1_err_d;
      s1_rd_q    <= s1_rd_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_valid_d;
      logic [PW-1:0]         s2_port_q, s2_port_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Output stage; data only moves on a response so it holds in between.
      always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_port_d   = s1_port_q;
        s2_err_d    = s1_err_q;
        s2_data_d   = s1_valid_q ? s1_data_s : s2_data_q;
        out_valid_s = s2_valid_q;
        out_port_s  = s2_port_q;
        out_err_s   = s2_err_q;
        out_data_s  = s2_data_q;
      end

      // Output stage registers.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          s2_valid_q <= 1'b0;
          s2_port_q  <= '0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_port_q  <= s2_port_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end
    end else begin : g_lat1
      logic [DATA_WIDTH-1:0] hold_q, hold_d;

      // Present stage 1 directly; hold_q keeps the last response data.
      always_comb begin
        hold_d      = s1_valid_q ? s1_data_s : hold_q;
        out_valid_s = s1_valid_q;
        out_port_s  = s1_port_q;
        out_err_s   = s1_err_q;
        out_data_s  = s1_valid_q ? s1_data_s : hold_q;
      end

      // Last-response data register.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          hold_q <= '0;
        end else begin
          hold_q <= hold_d;
        end
      end
    end
  endgenerate

  // Fan the response out to the owning port.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    if (out_valid_s) begin
      rsp_valid[out_port_s] = 1'b1;
      rsp_err[out_port_s]   = out_err_s;
    end else begin
      rsp_valid = '0;
    end
    rsp_rdata = out_data_s;
  end

endmodule

// File: tb/tb_dtcm_mp.sv
// tb_dtcm_mp: two dtcm_mp instances (fixed/latency-1 and RR/latency-2)
// driven side by side; expected responses are queued at accept time by a
// word-array reference model and popped by an independent monitor.
module tb_dtcm_mp;

  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 64;
  localparam int SB  = DW / 8;

  typedef struct {
    int             due;
    int             port;
    logic           err;
    logic [DW-1:0]  data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      valid [2];
  logic [N-1:0]      ready [2];
  logic [N-1:0]      we    [2];
  logic [N*SB-1:0]   strb  [2];
  logic [N*AW-1:0]   addr  [2];
  logic [N*DW-1:0]   wdata [2];
  logic [N-1:0]      rsp_valid [2];
  logic [N-1:0]      rsp_err   [2];
  logic [DW-1:0]     rdata     [2];

  int   cyc  = 0;
  int   vec  = 0;
  int   miss = 0;
  exp_t sbq [2][$];
  logic [DW-1:0] mdl_mem [2][DEP];
  int   lg  [2];
  int   gnt [2];
  bit   pend [2][N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtcm_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NUM_PORTS(N),
            .ARB_MODE(0), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_we(we[0]), .req_strb(strb[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .rsp_rdata(rdata[0]));

  dtcm_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NUM_PORTS(N),
            .ARB_MODE(1), .READ_LATENCY(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_we(we[1]), .req_strb(strb[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .rsp_rdata(rdata[1]));

  function automatic bit is_rr(input int d);
    return d == 1;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_req(input int d, input int p, input logic w, input logic [SB-1:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    valid[d][p]          = 1'b1;
    we[d][p]             = w;
    strb[d][p*SB +: SB]  = s;
    addr[d][p*AW +: AW]  = a;
    wdata[d][p*DW +: DW] = wd;
  endtask

  task automatic clr_all();
    valid[0] = '0;
    valid[1] = '0;
  endtask

  // Reference model for one cycle: arbitrate, check ready, apply access, queue response.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [N-1:0] exp_rdy;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = is_rr(d) ? (lg[d] + 1 + k) % N : k;
        if (g < 0 && valid[d][p]) g = p;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      vec++;
      if (ready[d] !== exp_rdy) begin
        miss++;
        $display("FAIL ready dut%0d cyc %0d: got %b want %b", d, cyc, ready[d], exp_rdy);
      end
      gnt[d] = g;
      if (!rstn) sbq[d].delete();
      if (g >= 0) begin
        int   a;
        int   w;
        bit   oor;
        exp_t e;
        a      = int'(addr[d][g*AW +: AW]);
        oor    = (a >= DEP * SB);
        w      = (a / SB) % DEP;
        e.due  = cyc + lat(d);
        e.port = g;
        e.err  = oor;
        e.data = '0;
        if (!oor && we[d][g]) begin
          for (int b = 0; b < SB; b++)
            if (strb[d][g*SB + b]) mdl_mem[d][w][b*8 +: 8] = wdata[d][g*DW + b*8 +: 8];
        end else if (!oor) begin
          e.data = mdl_mem[d][w];
        end
        if (rstn) sbq[d].push_back(e);
        lg[d] = rstn ? g : N - 1;
      end else if (!rstn) begin
        lg[d] = N - 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      logic [N-1:0] want_v;
      logic [N-1:0] want_e;
      if (rsp_valid[d] != '0) begin
        vec++;
        if (sbq[d].size() == 0) begin
          miss++;
          $display("FAIL unexpected_rsp dut%0d cyc %0d: got valid %b, want none", d, cyc, rsp_valid[d]);
        end else begin
          e = sbq[d].pop_front();
          want_v = '0;
          want_v[e.port] = 1'b1;
          want_e = e.err ? want_v : '0;
          if (cyc != e.due || rsp_valid[d] !== want_v || rsp_err[d] !== want_e || rdata[d] !== e.data) begin
            miss++;
            $display("FAIL rsp dut%0d: got cyc %0d valid %b err %b data %h, want cyc %0d valid %b err %b data %h",
                     d, cyc, rsp_valid[d], rsp_err[d], rdata[d], e.due, want_v, want_e, e.data);
          end
        end
      end else if (sbq[d].size() != 0 && sbq[d][0].due <= cyc) begin
        vec++;
        miss++;
        e = sbq[d].pop_front();
        $display("FAIL missing_rsp dut%0d cyc %0d: got none, want port %0d due %0d", d, cyc, e.port, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    lg[0] = N - 1;
    lg[1] = N - 1;
    rstn  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; we[d] = '0; strb[d] = '0; addr[d] = '0; wdata[d] = '0;
      for (int p = 0; p < N; p++) pend[d][p] = 1'b0;
    end
    @(negedge clk);
    #1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rsp_valid%0d", d), DW'(rsp_valid[d]), '0);
      chk($sformatf("reset_rsp_err%0d", d), DW'(rsp_err[d]), '0);
      chk($sformatf("reset_rdata%0d", d), rdata[d], '0);
    end
    rstn = 1'b1;

    // Fill both arrays with known data.
    for (int w = 0; w < DEP; w++) begin
      clr_all();
      for (int d = 0; d < 2; d++) set_req(d, w % N, 1'b1, 4'hF, AW'(w * SB), $urandom);
      step();
    end

    // Two partial overwrites then a read from a third port.
    clr_all();
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 4'b1111, 16'h0010, 32'hA5A5A5A5);
    step();
    clr_all();
    for (int d = 0; d < 2; d++) set_req(d, 1, 1'b1, 4'b0011, 16'h0010, 32'h0000FFFF);
    step();
    clr_all();
    for (int d = 0; d < 2; d++) set_req(d, 2, 1'b0, 4'b0000, 16'h0010, 32'h0);
    step();
    clr_all();
    chk("merge_data0", rdata[0], 32'hA5A5FFFF);
    chk("merge_valid0", DW'(rsp_valid[0]), DW'(3'b100));
    step();
    chk("merge_data1", rdata[1], 32'hA5A5FFFF);
    chk("merge_valid1", DW'(rsp_valid[1]), DW'(3'b100));

    // All ports reading: fixed priority vs rotation.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < N; p++) set_req(d, p, 1'b0, 4'h0, AW'((p + 1) * SB), 32'h0);
      #1;
      chk($sformatf("fixed_ready_%0d", i), DW'(ready[0]), DW'(3'b001));
      chk($sformatf("rr_ready_%0d", i), DW'(ready[1]), DW'(1 << (i % N)));
      step();
    end
    clr_all();

    // Out-of-range read and write; word 0 must stay intact.
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 4'h0, AW'(DEP * SB), 32'h0);
    step();
    chk("oor_err0", DW'(rsp_err[0]), DW'(3'b001));
    chk("oor_rdata0", rdata[0], '0);
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 4'hF, AW'(DEP * SB), 32'hDEADBEEF);
    step();
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b0, 4'h0, 16'h0000, 32'h0);
    step();
    clr_all();

    // Back-to-back reads of words 0..7 from port 1.
    for (int w = 0; w < 8; w++) begin
      for (int d = 0; d < 2; d++) set_req(d, 1, 1'b0, 4'h0, AW'(w * SB), 32'h0);
      step();
    end
    clr_all();
    step();
    step();

    // Reset right after a read accept; a write during reset still lands.
    set_req(1, 1, 1'b0, 4'h0, AW'(3 * SB), 32'h0);
    step();
    clr_all();
    rstn = 1'b0;
    set_req(0, 0, 1'b1, 4'hF, AW'(5 * SB), 32'h12345678);
    step();
    clr_all();
    chk("rst_mid_valid1", DW'(rsp_valid[1]), '0);
    chk("rst_mid_err1", DW'(rsp_err[1]), '0);
    chk("rst_mid_rdata1", rdata[1], '0);
    rstn = 1'b1;
    for (int p = 0; p < N; p++) set_req(1, p, 1'b0, 4'h0, AW'(p * SB), 32'h0);
    set_req(0, 0, 1'b0, 4'h0, AW'(5 * SB), 32'h0);
    #1;
    chk("rr_first_after_reset", DW'(ready[1]), DW'(3'b001));
    step();
    clr_all();
    step();
    step();

    // Randomized traffic; a pending request holds its payload until granted.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < N; p++) begin
          if (!pend[d][p]) begin
            if ($urandom_range(0, 99) < 60) begin
              if ($urandom_range(0, 9) == 0) ra = AW'(DEP * SB + $urandom_range(0, 4000));
              else ra = AW'($urandom_range(0, 15) * SB + $urandom_range(0, 3));
              set_req(d, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom);
              pend[d][p] = 1'b1;
            end else begin
              valid[d][p] = 1'b0;
            end
          end
        end
      end
      step();
      for (int d = 0; d < 2; d++)
        if (gnt[d] >= 0) pend[d][gnt[d]] = 1'b0;
    end
    clr_all();
    for (int i = 0; i < 4; i++) step();
    chk("drain0", DW'(sbq[0].size()), '0);
    chk("drain1", DW'(sbq[1].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
